serial_subtractor: RTL

Bit-serial N-bit subtractor computing diff = a - b, least significant bit first, one bit per clock. It reuses a single full-subtractor bit cell and a registered borrow. It is the inverse-direction companion to the team's combinational full adder. It sits between a valid/ready producer and a valid/ready consumer where area matters more than throughput.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, bout is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full_subtractor
// cell, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // The last bit goes straight into diff so DONE holds the full result.
                if (cnt_q == LAST_CNT) begin
                    diff_d       = {cell_d, res_q[WIDTH-1:1]};
                    borrow_out_d = cell_bout;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
    end

endmodule
